data_sram_responder: RTL
========================

// Module: data_sram_responder
// PURPOSE
//  Responder (memory side) of the CPU data_sram interface driven by the MEM stage.
//  Accepts en/wen/addr/wdata requests, performs byte-lane writes and returns rdata one cycle later.
//  After reset it runs a zero-fill sweep of the whole array and raises mem_ready when done.
//  Sits in the verify SoC between the CPU core and the on-chip data RAM.
// PARAMETERS
//  ADDR_W   12            word-address bits; DEPTH = 2**ADDR_W words (default 16 KB)
//  BASE     32'h0000_0000 byte base address; must be aligned to 4*DEPTH
// PORTS
//  clk              in   1   core clock, all state on rising edge
//  resetn           in   1   asynchronous, active-low reset
//  data_sram_en     in   1   request valid this cycle
//  data_sram_wen    in   4   byte-lane write enables, lane i = wdata[8i+7:8i]; 0000 = read
//  data_sram_addr   in   32  byte address; bits [1:0] ignored (lanes already positioned)
//  data_sram_wdata  in   32  lane-aligned store data
//  data_sram_rdata  out  32  registered read data, valid cycle after accepted request
//  mem_ready        out  1   high once the zero-fill sweep has completed
//  mem_err          out  1   one-cycle pulse, cycle after an out-of-range request
// BEHAVIOUR
//  Reset (resetn=0, async): rdata=0, mem_ready=0, mem_err=0, state=INIT, init_cnt=0.
//   Array itself has no reset; its contents are defined only by the sweep.
//  States: INIT -> RUN. No other transitions; only resetn returns to INIT.
//  INIT: each cycle write 32'h0 to word init_cnt, init_cnt++ (ADDR_W bits).
//   When init_cnt == DEPTH-1 is written, next state RUN; mem_ready=1 from the
//   first RUN cycle (sweep latency = DEPTH cycles after resetn deasserts).
//   Requests during INIT are ignored: no write, rdata holds 0, mem_err stays 0.
//  RUN, accepted request = data_sram_en=1:
//   idx = addr[ADDR_W+1:2]; in_range = (addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]).
//   in_range, wen!=0: lanes with wen[i]=1 updated at edge; others unchanged.
//   in_range: rdata <= word at idx after this cycle's write (write-first merge):
//     lane i = wen[i] ? wdata lane i : old lane i.
//   !in_range: no write, rdata <= 32'h0, mem_err=1 for exactly that next cycle.
//  data_sram_en=0: no write even if wen!=0; rdata holds last value; mem_err=0.
//  Back-to-back requests every cycle are supported; fixed read latency 1.
//  Read of an address written in the previous cycle returns the written data.
//  Reset mid-sweep or mid-RUN: restarts sweep from word 0, prior contents lost.
//  Address arithmetic: idx wraps naturally within ADDR_W bits; no carry into range test.
// STRUCTURE
//  Shared package: DATA_W=32, LANES=4, state enum {INIT, RUN}.
//  Sub-module dsram_bank: DEPTH x 32 array, per-lane write enable, one write
//   port + one synchronous read port, write-first on same-address collision.
//   Top owns FSM, init counter, range check, port mux (sweep vs CPU), mem_err.
// TESTING
//  1 Reset release -> mem_ready low for DEPTH cycles, high after; reads of
//    0x0, 0x3FFC return 32'h0 (proves sweep wrote every word).
//  2 Write 0x10 wen=1111 wdata=DEADBEEF, then read 0x10 -> rdata=DEADBEEF next cycle.
//  3 Word 0x20=11223344; write wen=0101 wdata=AABBCCDD; read -> 11BB33DD.
//  4 Same-cycle read/write: write 0x30 wen=0011 wdata=0000BEEF over 12345678,
//    rdata next cycle = 1234BEEF; following read 0x30 also 1234BEEF.
//  5 Access 0x0001_0000 (out of range, ADDR_W=12): mem_err pulses 1 cycle,
//    rdata=0, word 0x0 unchanged; en=0 with wen=1111 writes nothing.
//  6 Assert resetn low mid-RUN and mid-INIT -> outputs 0 immediately,
//    sweep restarts, previously written 0x10 reads 0 after mem_ready.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared types and helpers for the data_sram responder and its storage bank.
package data_sram_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  // Sweep (zero-fill) phase, then normal CPU service.
  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  // Byte-lane merge: lane i takes new data where wen[i] is set, else keeps old data.
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] new_word,
                                                   input logic [LANES-1:0]  wen);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(LANES); i++) begin
      if (wen[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_bank.sv
// DEPTH x 32 storage with per-lane write enables and a registered, write-first read port.
module data_sram_responder_bank
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned AddrW = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LANES-1:0]  wen_i,
  input  logic [AddrW-1:0]  addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rclr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] rdata_q;

  // Word as it will look after this cycle's write; also the write-first read value.
  assign merged = lane_merge(mem_q[addr_i], wdata_i, wen_i);

  // Array write; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (|wen_i) begin
      mem_q[addr_i] <= merged;
    end
  end

  // Read register: cleared on a rejected request, loaded on an accepted one, else held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (rclr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= merged;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data_sram port: zero-fill sweep after reset,
// then byte-lane writes and one-cycle registered reads with range checking.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_en,
  input  logic [LANES-1:0]  data_sram_wen,
  input  logic [31:0]       data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam logic [ADDR_W-1:0] CntOne = 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
  logic               err_q, err_d;

  logic               in_range;
  logic [LANES-1:0]   bank_wen;
  logic [ADDR_W-1:0]  bank_addr;
  logic [DATA_W-1:0]  bank_wdata;
  logic               bank_re;
  logic               bank_rclr;

  // Lane positioning is done by the requester, so the byte offset carries no information.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^data_sram_addr[1:0];

  // Only the bits above the word index decide range; the index itself wraps freely.
  assign in_range = (data_sram_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);

  // Next-state, sweep counter and bank port mux (sweep owns the port during StInit).
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    err_d      = 1'b0;
    bank_wen   = '0;
    bank_addr  = data_sram_addr[ADDR_W+1:2];
    bank_wdata = data_sram_wdata;
    bank_re    = 1'b0;
    bank_rclr  = 1'b0;
    unique case (state_q)
      StInit: begin
        bank_wen   = '1;
        bank_addr  = init_cnt_q;
        bank_wdata = '0;
        init_cnt_d = init_cnt_q + CntOne;
        if (init_cnt_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (data_sram_en) begin
          if (in_range) begin
            bank_wen = data_sram_wen;
            bank_re  = 1'b1;
          end else begin
            bank_rclr = 1'b1;
            err_d     = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  // State, sweep counter and error pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      err_q      <= err_d;
    end
  end

  data_sram_responder_bank #(
    .AddrW(ADDR_W)
  ) u_bank (
    .clk_i  (clk),
    .rst_ni (resetn),
    .wen_i  (bank_wen),
    .addr_i (bank_addr),
    .wdata_i(bank_wdata),
    .re_i   (bank_re),
    .rclr_i (bank_rclr),
    .rdata_o(data_sram_rdata)
  );

  assign mem_ready = (state_q == StRun);
  assign mem_err   = err_q;

endmodule
